// File: rtl/biss_c_frame_master.sv
// BiSS-C frame master: gates a divided clock onto MA for one frame and decodes the SLO reply.
// Optional CRC6 check is built when BISS_CRC_CHECK_EN is defined; otherwise crc_err_o stays 0.
module biss_c_frame_master #(
    parameter int DATA_BITS           = 26,
    parameter int ACK_TIMEOUT_EDGES   = 16,
    parameter int START_TIMEOUT_EDGES = 64,
    parameter int STOP_TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ma_div_i,
    input  logic                 start_i,
    input  logic                 slo_i,
    output logic                 ma_o,
    output logic                 busy_o,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 cds_o,
    output logic                 err_o,
    output logic                 warn_o,
    output logic                 crc_err_o,
    output logic                 timeout_o,
    output logic                 valid_o
);
    localparam int MAX_A = (ACK_TIMEOUT_EDGES > START_TIMEOUT_EDGES) ? ACK_TIMEOUT_EDGES
                                                                      : START_TIMEOUT_EDGES;
    localparam int MAX_B = (MAX_A > STOP_TIMEOUT_CYCLES) ? MAX_A : STOP_TIMEOUT_CYCLES;
    localparam int MAX_C = (MAX_B > DATA_BITS) ? MAX_B : DATA_BITS;
    localparam int CW    = $clog2(MAX_C + 1);

    typedef enum logic [3:0] {
        IDLE, ARM, WAIT_ACK, WAIT_START, CDS, DATA, EW, CRC, STOP, ABORT
    } state_t;

    state_t               state;
    logic                 slo_m, slo_s, ma_q;
    logic                 rise, fall;
    logic [CW-1:0]        cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 cds_r, ne_r, nw_r;
    logic                 crc_bad;

    assign rise = ma_div_i & ~ma_q;
    assign fall = ~ma_div_i & ma_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slo_m <= 1'b1;
            slo_s <= 1'b1;
            ma_q  <= 1'b1;
        end else begin
            slo_m <= slo_i;
            slo_s <= slo_m;
            ma_q  <= ma_div_i;
        end
    end

`ifdef BISS_CRC_CHECK_EN
    logic [5:0] crc_calc, rx_crc;
    logic       crc_fb;

    assign crc_fb  = slo_s ^ crc_calc[5];
    // Sender transmits the inverted remainder.
    assign crc_bad = (rx_crc != ~crc_calc);

    always_ff @(posedge clk_i) begin
        if (rst_i || state == ARM) begin
            crc_calc <= '0;
            rx_crc   <= '0;
        end else if (rise) begin
            if (state == DATA || state == EW)
                crc_calc <= {crc_calc[4:0], 1'b0} ^ ({6{crc_fb}} & 6'h03);
            if (state == CRC)
                rx_crc <= {rx_crc[4:0], slo_s};
        end
    end
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            cds_r     <= 1'b0;
            ne_r      <= 1'b1;
            nw_r      <= 1'b1;
            ma_o      <= 1'b1;
            busy_o    <= 1'b0;
            data_o    <= '0;
            cds_o     <= 1'b0;
            err_o     <= 1'b0;
            warn_o    <= 1'b0;
            crc_err_o <= 1'b0;
            timeout_o <= 1'b0;
            valid_o   <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    ma_o <= 1'b1;
                    // A request landing on the completion pulse is dropped.
                    if (start_i && !valid_o) begin
                        state  <= ARM;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                    end
                end
                ARM: begin
                    ma_o <= 1'b1;
                    if (fall) begin
                        state <= WAIT_ACK;
                        cnt   <= '0;
                        ma_o  <= ma_div_i;
                    end
                end
                WAIT_ACK: begin
                    ma_o <= ma_div_i;
                    if (rise) begin
                        if (!slo_s) begin
                            state <= WAIT_START;
                            cnt   <= '0;
                        end else if (cnt == CW'(ACK_TIMEOUT_EDGES - 1)) begin
                            state <= ABORT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                WAIT_START: begin
                    ma_o <= ma_div_i;
                    if (rise) begin
                        if (slo_s) begin
                            state <= CDS;
                            cnt   <= '0;
                        end else if (cnt == CW'(START_TIMEOUT_EDGES - 1)) begin
                            state <= ABORT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                CDS: begin
                    ma_o <= ma_div_i;
                    if (rise) begin
                        cds_r <= slo_s;
                        state <= DATA;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    ma_o <= ma_div_i;
                    if (rise) begin
                        shreg <= DATA_BITS'({shreg, slo_s});
                        if (cnt == CW'(DATA_BITS - 1)) begin
                            state <= EW;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                EW: begin
                    ma_o <= ma_div_i;
                    if (rise) begin
                        if (cnt == '0) begin
                            ne_r <= slo_s;
                            cnt  <= cnt + 1'b1;
                        end else begin
                            nw_r  <= slo_s;
                            state <= CRC;
                            cnt   <= '0;
                        end
                    end
                end
                CRC: begin
                    ma_o <= ma_div_i;
                    if (rise) begin
                        if (cnt == CW'(5)) begin
                            state <= STOP;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    ma_o <= 1'b1;
                    if (slo_s) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        busy_o    <= 1'b0;
                        valid_o   <= 1'b1;
                        data_o    <= shreg;
                        cds_o     <= cds_r;
                        err_o     <= ~ne_r;
                        warn_o    <= ~nw_r;
                        crc_err_o <= crc_bad;
                        timeout_o <= 1'b0;
                    end else if (cnt == CW'(STOP_TIMEOUT_CYCLES - 1)) begin
                        state <= ABORT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ABORT: begin
                    ma_o      <= 1'b1;
                    timeout_o <= 1'b1;
                    valid_o   <= 1'b1;
                    busy_o    <= 1'b0;
                    state     <= IDLE;
                    cnt       <= '0;
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    ma_o   <= 1'b1;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_biss_c_frame_master.sv
// Bench for biss_c_frame_master: encoder model replies to MA edges, scoreboard holds expected frames.
module tb_biss_c_frame_master;
    logic        clk = 1'b0;
    logic        rst_i, ma_div_i, start_i, slo_i;
    logic        ma_o, busy_o, cds_o, err_o, warn_o, crc_err_o, timeout_o, valid_o;
    logic [25:0] data_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          nvalid;
        int          rises;
        logic [25:0] data;
        logic        cds, err, warn, crc_err, tmo;
    } exp_t;

    typedef struct {
        int          nvalid;
        int          rises;
        logic [25:0] data;
        logic        cds, err, warn, crc_err, tmo, ma, busy_end, rst_ma, rst_busy;
    } obs_t;

    exp_t        sb[$];
    bit          seq[$];
    logic [25:0] last_data;

    biss_c_frame_master dut (
        .clk_i(clk), .rst_i(rst_i), .ma_div_i(ma_div_i), .start_i(start_i), .slo_i(slo_i),
        .ma_o(ma_o), .busy_o(busy_o), .data_o(data_o), .cds_o(cds_o), .err_o(err_o),
        .warn_o(warn_o), .crc_err_o(crc_err_o), .timeout_o(timeout_o), .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    // Free-running divider: 5 clk high, 5 clk low.
    int dcnt = 0;
    initial ma_div_i = 1'b1;
    always @(negedge clk) begin
        dcnt = (dcnt == 9) ? 0 : dcnt + 1;
        ma_div_i = (dcnt < 5);
    end

    // Remainder of M(x)*x^6 mod x^6+x+1 by long division.
    function automatic logic [5:0] crc6(input logic [25:0] d, input bit ne, input bit nw);
        logic [6:0]  r;
        logic [27:0] m;
        r = '0;
        m = {d, ne, nw};
        for (int i = 33; i >= 0; i--) begin
            r = {r[5:0], (i >= 6) ? m[i-6] : 1'b0};
            if (r[6]) r = r ^ 7'h43;
        end
        return r[5:0];
    endfunction

    function automatic void build_seq(input logic [25:0] d, input bit cds, input bit ne,
                                      input bit nw, input bit flip);
        logic [5:0] c;
        seq.delete();
        seq.push_back(1'b1);  // rise 1: no ack yet
        seq.push_back(1'b0);  // rise 2: ack
        seq.push_back(1'b0);
        seq.push_back(1'b1);  // rise 4: start
        seq.push_back(cds);
        for (int i = 25; i >= 0; i--) seq.push_back(d[i]);
        seq.push_back(ne);
        seq.push_back(nw);
        c = ~crc6(d, ne, nw);
        if (flip) c[2] = ~c[2];
        for (int i = 5; i >= 0; i--) seq.push_back(c[i]);
    endfunction

    task automatic drive_frame(input bit enc_on, input int stop_low, input int mid_start,
                               input int rst_at, input bit start_on_valid, input int budget,
                               output obs_t o);
        int low_left, tail;
        bit prev_ma;
        o = '{default: 0};
        low_left = 0;
        tail = -1;
        prev_ma = ma_o;
        slo_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int cyc = 0; cyc < budget && tail != 0; cyc++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (rst_at >= 0 && cyc == rst_at + 1) begin
                o.rst_ma = ma_o;
                o.rst_busy = busy_o;
                rst_i = 1'b0;
            end
            if (cyc == rst_at) rst_i = 1'b1;
            if (valid_o) begin
                o.nvalid++;
                if (o.nvalid == 1) begin
                    o.data = data_o; o.cds = cds_o; o.err = err_o; o.warn = warn_o;
                    o.crc_err = crc_err_o; o.tmo = timeout_o; o.ma = ma_o;
                    tail = 20;
                    if (start_on_valid) start_i = 1'b1;
                end
            end
            if (tail > 0) tail--;
            if (low_left > 0) begin
                low_left--;
                if (low_left == 0) slo_i = 1'b1;
            end
            if (ma_o && !prev_ma) begin
                o.rises++;
                if (enc_on && o.rises < seq.size()) slo_i = seq[o.rises];
                else if (enc_on && o.rises == seq.size()) begin
                    slo_i = 1'b0;
                    low_left = stop_low;
                end
            end
            prev_ma = ma_o;
            if (cyc == mid_start) start_i = 1'b1;
        end
        @(negedge clk);
        start_i = 1'b0;
        slo_i = 1'b1;
        o.busy_end = busy_o;
    endtask

    task automatic push_ok(input logic [25:0] d, input bit cds, input bit ne, input bit nw,
                           input bit crc_bad);
        exp_t e;
        e = '{nvalid: 1, rises: 39, data: d, cds: cds, err: ~ne, warn: ~nw,
              crc_err: crc_bad, tmo: 1'b0};
        sb.push_back(e);
        last_data = d;
    endtask

    task automatic test_reset;
        rst_i = 1'b1; start_i = 1'b0; slo_i = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (ma_o !== 1'b1) begin errors++; $display("FAIL reset.ma got %b exp 1", ma_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset.busy got %b exp 0", busy_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset.valid got %b exp 0", valid_o); end
        checks++; if (data_o !== 26'h0) begin errors++; $display("FAIL reset.data got %h exp 0", data_o); end
        checks++; if ({cds_o, err_o, warn_o, crc_err_o, timeout_o} !== 5'b0) begin
            errors++; $display("FAIL reset.flags got %b exp 00000", {cds_o, err_o, warn_o, crc_err_o, timeout_o});
        end
        rst_i = 1'b0;
        last_data = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy_o !== 1'b0 || ma_o !== 1'b1) begin
            errors++; $display("FAIL reset.idle got busy=%b ma=%b exp busy=0 ma=1", busy_o, ma_o);
        end
    endtask

    task automatic test_good_frame;
        obs_t o; exp_t e;
        build_seq(26'h1234567, 1'b0, 1'b1, 1'b1, 1'b0);
        push_ok(26'h1234567, 1'b0, 1'b1, 1'b1, 1'b0);
        drive_frame(1'b1, 20, -1, -1, 1'b0, 1500, o);
        e = sb.pop_front();
        checks++; if (o.nvalid !== e.nvalid) begin errors++; $display("FAIL good.nvalid got %0d exp %0d", o.nvalid, e.nvalid); end
        checks++; if (o.data !== e.data) begin errors++; $display("FAIL good.data got %h exp %h", o.data, e.data); end
        checks++; if (o.cds !== e.cds) begin errors++; $display("FAIL good.cds got %b exp %b", o.cds, e.cds); end
        checks++; if (o.err !== e.err) begin errors++; $display("FAIL good.err got %b exp %b", o.err, e.err); end
        checks++; if (o.warn !== e.warn) begin errors++; $display("FAIL good.warn got %b exp %b", o.warn, e.warn); end
        checks++; if (o.crc_err !== e.crc_err) begin errors++; $display("FAIL good.crc_err got %b exp %b", o.crc_err, e.crc_err); end
        checks++; if (o.tmo !== e.tmo) begin errors++; $display("FAIL good.timeout got %b exp %b", o.tmo, e.tmo); end
        checks++; if (o.ma !== 1'b1) begin errors++; $display("FAIL good.ma got %b exp 1", o.ma); end
        checks++; if (o.rises !== e.rises) begin errors++; $display("FAIL good.rises got %0d exp %0d", o.rises, e.rises); end
        checks++; if (o.busy_end !== 1'b0) begin errors++; $display("FAIL good.busy_end got %b exp 0", o.busy_end); end
    endtask

    task automatic test_crc_flip;
        obs_t o; exp_t e; bit bad;
`ifdef BISS_CRC_CHECK_EN
        bad = 1'b1;
`else
        bad = 1'b0;
`endif
        build_seq(26'h1234567, 1'b0, 1'b1, 1'b1, 1'b1);
        push_ok(26'h1234567, 1'b0, 1'b1, 1'b1, bad);
        drive_frame(1'b1, 20, -1, -1, 1'b0, 1500, o);
        e = sb.pop_front();
        checks++; if (o.nvalid !== e.nvalid) begin errors++; $display("FAIL crc.nvalid got %0d exp %0d", o.nvalid, e.nvalid); end
        checks++; if (o.data !== e.data) begin errors++; $display("FAIL crc.data got %h exp %h", o.data, e.data); end
        checks++; if (o.crc_err !== e.crc_err) begin errors++; $display("FAIL crc.crc_err got %b exp %b", o.crc_err, e.crc_err); end
        checks++; if (o.tmo !== e.tmo) begin errors++; $display("FAIL crc.timeout got %b exp %b", o.tmo, e.tmo); end
    endtask

    task automatic test_no_encoder;
        obs_t o; exp_t e;
        e = '{nvalid: 1, rises: 16, data: last_data, cds: 1'b0, err: 1'b0, warn: 1'b0,
              crc_err: 1'b0, tmo: 1'b1};
        sb.push_back(e);
        drive_frame(1'b0, 0, -1, -1, 1'b0, 1000, o);
        e = sb.pop_front();
        checks++; if (o.nvalid !== e.nvalid) begin errors++; $display("FAIL noenc.nvalid got %0d exp %0d", o.nvalid, e.nvalid); end
        checks++; if (o.tmo !== e.tmo) begin errors++; $display("FAIL noenc.timeout got %b exp %b", o.tmo, e.tmo); end
        checks++; if (o.data !== e.data) begin errors++; $display("FAIL noenc.data got %h exp %h", o.data, e.data); end
        checks++; if (o.ma !== 1'b1) begin errors++; $display("FAIL noenc.ma got %b exp 1", o.ma); end
        checks++; if (o.rises !== e.rises) begin errors++; $display("FAIL noenc.rises got %0d exp %0d", o.rises, e.rises); end
    endtask

    task automatic test_flags;
        obs_t o; exp_t e;
        build_seq(26'h2A5A5A5, 1'b1, 1'b0, 1'b1, 1'b0);
        push_ok(26'h2A5A5A5, 1'b1, 1'b0, 1'b1, 1'b0);
        drive_frame(1'b1, 20, -1, -1, 1'b0, 1500, o);
        e = sb.pop_front();
        checks++; if (o.nvalid !== e.nvalid) begin errors++; $display("FAIL flags.nvalid got %0d exp %0d", o.nvalid, e.nvalid); end
        checks++; if (o.cds !== e.cds) begin errors++; $display("FAIL flags.cds got %b exp %b", o.cds, e.cds); end
        checks++; if (o.err !== e.err) begin errors++; $display("FAIL flags.err got %b exp %b", o.err, e.err); end
        checks++; if (o.warn !== e.warn) begin errors++; $display("FAIL flags.warn got %b exp %b", o.warn, e.warn); end
        checks++; if (o.tmo !== e.tmo) begin errors++; $display("FAIL flags.timeout got %b exp %b", o.tmo, e.tmo); end
        checks++; if (o.data !== e.data) begin errors++; $display("FAIL flags.data got %h exp %h", o.data, e.data); end
    endtask

    task automatic test_reset_mid;
        obs_t o; exp_t e;
        build_seq(26'h1111111, 1'b0, 1'b1, 1'b1, 1'b0);
        drive_frame(1'b1, 20, -1, 150, 1'b0, 600, o);
        last_data = '0;
        checks++; if (o.rst_ma !== 1'b1) begin errors++; $display("FAIL rstmid.ma got %b exp 1", o.rst_ma); end
        checks++; if (o.rst_busy !== 1'b0) begin errors++; $display("FAIL rstmid.busy got %b exp 0", o.rst_busy); end
        checks++; if (o.nvalid !== 0) begin errors++; $display("FAIL rstmid.nvalid got %0d exp 0", o.nvalid); end
        checks++; if (data_o !== last_data) begin errors++; $display("FAIL rstmid.data got %h exp %h", data_o, last_data); end
        build_seq(26'h0FEDCBA, 1'b0, 1'b1, 1'b1, 1'b0);
        push_ok(26'h0FEDCBA, 1'b0, 1'b1, 1'b1, 1'b0);
        drive_frame(1'b1, 20, -1, -1, 1'b0, 1500, o);
        e = sb.pop_front();
        checks++; if (o.nvalid !== e.nvalid) begin errors++; $display("FAIL rstmid.next_nvalid got %0d exp %0d", o.nvalid, e.nvalid); end
        checks++; if (o.data !== e.data) begin errors++; $display("FAIL rstmid.next_data got %h exp %h", o.data, e.data); end
        checks++; if (o.crc_err !== e.crc_err) begin errors++; $display("FAIL rstmid.next_crc got %b exp %b", o.crc_err, e.crc_err); end
    endtask

    task automatic test_back_to_back;
        obs_t o; exp_t e;
        build_seq(26'h3000001, 1'b0, 1'b1, 1'b1, 1'b0);
        push_ok(26'h3000001, 1'b0, 1'b1, 1'b1, 1'b0);
        drive_frame(1'b1, 20, 100, -1, 1'b1, 1500, o);
        e = sb.pop_front();
        checks++; if (o.nvalid !== e.nvalid) begin errors++; $display("FAIL b2b.nvalid got %0d exp %0d", o.nvalid, e.nvalid); end
        checks++; if (o.data !== e.data) begin errors++; $display("FAIL b2b.data got %h exp %h", o.data, e.data); end
        checks++; if (o.busy_end !== 1'b0) begin errors++; $display("FAIL b2b.busy_end got %b exp 0", o.busy_end); end
    endtask

    task automatic test_stop_timeout;
        obs_t o; exp_t e;
        logic [25:0] d;
        logic [5:0]  c;
        // Last transmitted CRC bit must be 0 so SLO is low on entry to STOP.
        d = 26'h0ABCDE;
        c = crc6(d, 1'b1, 1'b1);
        while (c[0] !== 1'b1) begin
            d = d + 1'b1;
            c = crc6(d, 1'b1, 1'b1);
        end
        build_seq(d, 1'b0, 1'b1, 1'b1, 1'b0);
        e = '{nvalid: 1, rises: 39, data: last_data, cds: 1'b0, err: 1'b0, warn: 1'b0,
              crc_err: 1'b0, tmo: 1'b1};
        sb.push_back(e);
        drive_frame(1'b1, 5000, -1, -1, 1'b0, 6000, o);
        e = sb.pop_front();
        checks++; if (o.nvalid !== e.nvalid) begin errors++; $display("FAIL stop.nvalid got %0d exp %0d", o.nvalid, e.nvalid); end
        checks++; if (o.tmo !== e.tmo) begin errors++; $display("FAIL stop.timeout got %b exp %b", o.tmo, e.tmo); end
        checks++; if (o.data !== e.data) begin errors++; $display("FAIL stop.data got %h exp %h", o.data, e.data); end
        checks++; if (o.rises !== e.rises) begin errors++; $display("FAIL stop.rises got %0d exp %0d", o.rises, e.rises); end
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; slo_i = 1'b1;
        test_reset;
        test_good_frame;
        test_crc_flip;
        test_no_encoder;
        test_flags;
        test_reset_mid;
        test_back_to_back;
        test_stop_timeout;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
